// File: rtl/des_pkg.sv
// Shared definitions for the DES key schedule.
// Holds the PC-1 table (0-based, MSB-first bit numbering), the per-round rotate
// amounts for both directions, the FSM state type, width constants and the
// rotation / parity helpers.
// No ports; imported with `import des_pkg::*;`.
package des_pkg;

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned CD_W   = 56;
  localparam int unsigned HALF_W = 28;

  // Index 0 is DES bit 1 (MSB of the key). Output bit i of PC-1 takes key bit PC1_TABLE[i].
  localparam int unsigned PC1_TABLE [CD_W] = '{
    56, 48, 40, 32, 24, 16,  8,
     0, 57, 49, 41, 33, 25, 17,
     9,  1, 58, 50, 42, 34, 26,
    18, 10,  2, 59, 51, 43, 35,
    62, 54, 46, 38, 30, 22, 14,
     6, 61, 53, 45, 37, 29, 21,
    13,  5, 60, 52, 44, 36, 28,
    20, 12,  4, 27, 19, 11,  3
  };

  // Left-rotate amount producing round r (entry r-1) when encrypting.
  localparam logic [1:0] ENC_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Right-rotate amount applied to enter round j (entry j-1) when decrypting.
  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic [0:0] {StIdle, StRound} des_state_e;

  // Rotate one 28-bit half; bit 0 is the MSB, so "left" moves bits towards index 0.
  function automatic logic [0:HALF_W-1] rot_half(logic [0:HALF_W-1] x, logic [1:0] amt,
                                                  logic left);
    logic [0:HALF_W-1] y;
    for (int unsigned i = 0; i < HALF_W; i++) begin
      if (left) y[i] = x[(i + amt) % HALF_W];
      else      y[i] = x[(i + HALF_W - amt) % HALF_W];
    end
    return y;
  endfunction

  // C and D rotate independently, each wrapping within its own 28 bits.
  function automatic logic [0:CD_W-1] rot_cd(logic [0:CD_W-1] cd, logic [1:0] amt, logic left);
    return {rot_half(cd[0:HALF_W-1], amt, left), rot_half(cd[HALF_W:CD_W-1], amt, left)};
  endfunction

  // 1 when every key byte has odd parity.
  function automatic logic key_odd_parity(logic [0:KEY_W-1] key);
    logic ok;
    ok = 1'b1;
    for (int unsigned b = 0; b < KEY_W / 8; b++) begin
      ok &= ^key[8*b +: 8];
    end
    return ok;
  endfunction

endpackage

// File: rtl/des_key_permutation1.sv
// DES Permuted Choice 1: selects the 56 key bits that form C0||D0.
// Ports:
//   i_key  [0:63] DES key, bit 0 = DES bit 1
//   o_cd   [0:55] C0 (bits 0:27) || D0 (bits 28:55)
// Purely combinational; the eight parity bits are dropped.
module des_key_permutation1
  import des_pkg::*;
(
  input  logic [0:KEY_W-1] i_key,
  output logic [0:CD_W-1]  o_cd
);

  for (genvar i = 0; i < CD_W; i++) begin : g_pc1
    assign o_cd[i] = i_key[PC1_TABLE[i]];
  end

  // Parity bits never reach the schedule; sink them explicitly.
  logic w_unused_parity;
  assign w_unused_parity = ^{i_key[7], i_key[15], i_key[23], i_key[31],
                             i_key[39], i_key[47], i_key[55], i_key[63]};

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key-schedule generator. Applies PC-1 to the loaded key and
// emits the 16 per-round C||D values (PC-2 input) in encrypt or decrypt order,
// one per accepted valid/ready transfer.
// Ports:
//   clk, n_rst       clock, synchronous active-low reset
//   key_in [0:63]    key, sampled on an accepted load
//   key_load         load request, honoured only when idle
//   decrypt          direction, sampled with key_in (1 = decrypt order)
//   round_ready      downstream accepts the current C||D
//   round_cd [0:55]  C||D for the current round
//   round_num [3:0]  current round; 0 when idle
//   round_valid      round_cd/round_num valid
//   busy             schedule in progress
//   done             one-cycle pulse after round 16 is transferred
//   parity_err       rejected load (only with DES_KEY_PARITY_CHECK_EN)
// Optional feature macro: DES_KEY_PARITY_CHECK_EN (odd parity required on every key byte).
module des_key_schedule
  import des_pkg::*;
#(
  // Fixed by DES; the shift tables hold exactly 16 entries.
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [0:KEY_W-1]  key_in,
  input  logic              key_load,
  input  logic              decrypt,
  input  logic              round_ready,
  output logic [0:CD_W-1]   round_cd,
  output logic [3:0]        round_num,
  output logic              round_valid,
  output logic              busy,
  output logic              done,
  output logic              parity_err
);

  des_state_e      r_state, w_state_d;
  logic [0:CD_W-1] r_cd, w_cd_d, w_cd0;
  logic [4:0]      r_round, w_round_d;
  logic            r_dec, w_dec_d;
  logic            r_done, w_done_d;
  logic            r_perr, w_perr_d;
  logic            w_load_req, w_load_ok, w_transfer, w_last, w_key_par_bad;

  des_key_permutation1 u_pc1 (
    .i_key (key_in),
    .o_cd  (w_cd0)
  );

`ifdef DES_KEY_PARITY_CHECK_EN
  assign w_key_par_bad = !key_odd_parity(key_in);
`else
  assign w_key_par_bad = 1'b0;
`endif

  assign w_load_req = (r_state == StIdle) && key_load;
  assign w_load_ok  = w_load_req && !w_key_par_bad;
  assign w_transfer = (r_state == StRound) && round_ready;
  assign w_last     = (r_round == 5'(NUM_ROUNDS));

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_load_ok) w_state_d = StRound;
      StRound: if (w_transfer && w_last) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Datapath next values: CD rotation, round counter, direction, pulses
  always_comb begin
    w_cd_d    = r_cd;
    w_round_d = r_round;
    w_dec_d   = r_dec;
    w_done_d  = 1'b0;
    w_perr_d  = w_load_req && w_key_par_bad;
    if (w_load_ok) begin
      w_dec_d   = decrypt;
      w_round_d = 5'd1;
      // Decrypt round 1 is CD0 itself (right rotate by 0).
      w_cd_d    = decrypt ? w_cd0 : rot_cd(w_cd0, ENC_SHIFT[0], 1'b1);
    end else if (w_transfer) begin
      if (w_last) begin
        w_cd_d    = '0;
        w_round_d = '0;
        w_done_d  = 1'b1;
      end else begin
        w_round_d = r_round + 5'd1;
        // r_round (1..15) is also the 0-based table index of the next round.
        w_cd_d    = r_dec ? rot_cd(r_cd, DEC_SHIFT[r_round[3:0]], 1'b0)
                          : rot_cd(r_cd, ENC_SHIFT[r_round[3:0]], 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_cd    <= '0;
      r_round <= '0;
      r_dec   <= 1'b0;
      r_done  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_cd    <= w_cd_d;
      r_round <= w_round_d;
      r_dec   <= w_dec_d;
      r_done  <= w_done_d;
      r_perr  <= w_perr_d;
    end
  end

  // Outputs. Round 16 wraps to 0 on the 4-bit round_num port; round_valid
  // tells it apart from idle.
  always_comb begin
    round_valid = (r_state == StRound);
    busy        = (r_state == StRound);
    round_cd    = r_cd;
    round_num   = r_round[3:0];
    done        = r_done;
    parity_err  = r_perr;
  end

endmodule

// File: tb/tb_des_key_schedule.sv
`timescale 1ns/1ps
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [0:63] key_in;
  logic        key_load, decrypt, round_ready;
  logic [0:55] round_cd;
  logic [3:0]  round_num;
  logic        round_valid, busy, done, parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;

  always #5 clk = ~clk;

  des_key_schedule #(.NUM_ROUNDS(16)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .key_in      (key_in),
    .key_load    (key_load),
    .decrypt     (decrypt),
    .round_ready (round_ready),
    .round_cd    (round_cd),
    .round_num   (round_num),
    .round_valid (round_valid),
    .busy        (busy),
    .done        (done),
    .parity_err  (parity_err)
  );

  // PC-1 in textbook 1-based DES numbering, and the encrypt shift schedule.
  int pc1_des [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                       10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                       63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                       14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Round value = CD0 halves each rotated left by the cumulative shift count;
  // decrypt round j is encrypt round 17-j.
  function automatic logic [55:0] model_cd(logic [63:0] key, int rnd, bit dec);
    logic [55:0] cd0, tc, td;
    int k, s;
    for (int i = 0; i < 56; i++) cd0[55-i] = key[64 - pc1_des[i]];
    k = dec ? 17 - rnd : rnd;
    s = 0;
    for (int i = 0; i < k; i++) s += shifts[i];
    s = s % 28;
    tc = {cd0[55:28], cd0[55:28]} << s;
    td = {cd0[27:0], cd0[27:0]} << s;
    return {tc[55:28], td[55:28]};
  endfunction

  function automatic logic [63:0] fix_parity(logic [63:0] k);
    for (int b = 0; b < 8; b++) k[8*b] = ~(^k[8*b+1 +: 7]);
    return k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] k, input bit dec);
    key_in   = k;
    decrypt  = dec;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
  endtask

  // Runs the rest of a schedule with round_ready high, bounded.
  task automatic drain();
    int cyc;
    cyc = 0;
    round_ready = 1'b1;
    while (done !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_timeout: done=%b after %0d cycles, required 1", done, cyc);
    end
    step();
  endtask

  task automatic test_reset();
    n_rst = 1'b0; key_load = 1'b0; decrypt = 1'b0; round_ready = 1'b0; key_in = '0;
    step(); step();
    n_checks++;
    if ({round_cd, round_num, round_valid, busy, done, parity_err} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: cd=%h n=%0d v=%b b=%b d=%b p=%b, required all 0",
               round_cd, round_num, round_valid, busy, done, parity_err);
    end
    n_rst = 1'b1;
    step();
    n_checks++;
    if ({round_valid, busy, round_num} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_idle: v=%b b=%b n=%0d, required 0", round_valid, busy, round_num);
    end
  endtask

  task automatic test_known(input bit dec);
    logic [55:0] first, last;
    first = dec ? 56'hF0CCAAF556678F : 56'hE19955FAACCF1E;
    last  = dec ? 56'hE19955FAACCF1E : 56'hF0CCAAF556678F;
    round_ready = 1'b1;
    load(KNOWN_KEY, dec);
    for (int j = 1; j <= 16; j++) begin
      n_checks++;
      if ({round_valid, busy, round_num, round_cd} !== {2'b11, 4'(j), model_cd(KNOWN_KEY, j, dec)})
      begin
        n_fail++;
        $display("FAIL known_dec%0d_round%0d: v=%b b=%b n=%0d cd=%h, required n=%0d cd=%h",
                 dec, j, round_valid, busy, round_num, round_cd, 4'(j),
                 model_cd(KNOWN_KEY, j, dec));
      end
      if (j == 1 || j == 16 || (dec && j == 2)) begin
        n_checks++;
        if (round_cd !== (j == 1 ? first : j == 16 ? last : 56'hF866557AAB33C7)) begin
          n_fail++;
          $display("FAIL vector_dec%0d_round%0d: cd=%h", dec, j, round_cd);
        end
      end
      step();
    end
    n_checks++;
    if ({done, round_valid, busy, round_num, round_cd} !== {1'b1, 62'd0}) begin
      n_fail++;
      $display("FAIL done_pulse_dec%0d: d=%b v=%b b=%b n=%0d cd=%h, required d=1 rest 0",
               dec, done, round_valid, busy, round_num, round_cd);
    end
    step();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width_dec%0d: done=%b, required 0", dec, done);
    end
  endtask

  task automatic test_backpressure();
    int j, xfers, stall, cyc;
    j = 1; xfers = 0; stall = 0; cyc = 0;
    round_ready = 1'b1;
    load(KNOWN_KEY, 1'b0);
    while (done !== 1'b1 && cyc < 100) begin
      round_ready = !(j == 5 && stall < 3);
      n_checks++;
      if ({round_valid, round_num, round_cd} !== {1'b1, 4'(j), model_cd(KNOWN_KEY, j, 0)}) begin
        n_fail++;
        $display("FAIL bp_round%0d: v=%b n=%0d cd=%h, required cd=%h", j, round_valid,
                 round_num, round_cd, model_cd(KNOWN_KEY, j, 0));
      end
      if (round_valid && round_ready) begin xfers++; j++; end
      else stall++;
      step();
      cyc++;
    end
    n_checks++;
    if (xfers != 16 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_transfers: xfers=%0d done=%b, required 16 and 1", xfers, done);
    end
    step();
  endtask

  task automatic test_load_ignored();
    logic [63:0] ka, kb;
    ka = fix_parity({$urandom, $urandom});
    kb = fix_parity({$urandom, $urandom});
    round_ready = 1'b1;
    load(ka, 1'b0);
    for (int j = 1; j <= 16; j++) begin
      if (j == 8) begin key_in = kb; decrypt = 1'b1; key_load = 1'b1; end
      else key_load = 1'b0;
      n_checks++;
      if ({round_valid, round_num, round_cd} !== {1'b1, 4'(j), model_cd(ka, j, 0)}) begin
        n_fail++;
        $display("FAIL ignored_load_round%0d: v=%b n=%0d cd=%h, required cd=%h", j,
                 round_valid, round_num, round_cd, model_cd(ka, j, 0));
      end
      step();
    end
    key_load = 1'b0;
    n_checks++;
    if (done !== 1'b1 || round_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_load_done: done=%b v=%b, required 1 and 0", done, round_valid);
    end
    step();
  endtask

  task automatic test_midreset();
    logic [63:0] k2;
    k2 = fix_parity({$urandom, $urandom});
    round_ready = 1'b1;
    load(KNOWN_KEY, 1'b0);
    for (int j = 1; j < 10; j++) step();
    n_checks++;
    if (round_num !== 4'd10) begin
      n_fail++;
      $display("FAIL midreset_reach: n=%0d, required 10", round_num);
    end
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    n_checks++;
    if ({round_cd, round_num, round_valid, busy, done, parity_err} !== 64'd0) begin
      n_fail++;
      $display("FAIL midreset_clear: cd=%h n=%0d v=%b b=%b d=%b, required all 0",
               round_cd, round_num, round_valid, busy, done);
    end
    load(k2, 1'b1);
    n_checks++;
    if ({round_valid, round_num, round_cd} !== {1'b1, 4'd1, model_cd(k2, 1, 1)}) begin
      n_fail++;
      $display("FAIL midreset_restart: v=%b n=%0d cd=%h, required n=1 cd=%h",
               round_valid, round_num, round_cd, model_cd(k2, 1, 1));
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [63:0] kb;
    kb = fix_parity({$urandom, $urandom});
    round_ready = 1'b1;
    load(KNOWN_KEY, 1'b0);
    for (int j = 1; j < 16; j++) step();
    // Load during the round-16 transfer must be ignored, then taken in the done cycle.
    key_in = kb; decrypt = 1'b1; key_load = 1'b1;
    step();
    n_checks++;
    if (done !== 1'b1 || round_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b v=%b, required 1 and 0", done, round_valid);
    end
    step();
    key_load = 1'b0;
    n_checks++;
    if ({done, round_valid, round_num, round_cd} !== {2'b01, 4'd1, model_cd(kb, 1, 1)}) begin
      n_fail++;
      $display("FAIL b2b_reload: d=%b v=%b n=%0d cd=%h, required 0 1 1 %h", done,
               round_valid, round_num, round_cd, model_cd(kb, 1, 1));
    end
    drain();
  endtask

  task automatic test_parity();
    round_ready = 1'b1;
`ifdef DES_KEY_PARITY_CHECK_EN
    load(64'h133457799BBCDFF0, 1'b0);
    n_checks++;
    if (parity_err !== 1'b1 || round_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_reject: perr=%b v=%b, required 1 and 0", parity_err, round_valid);
    end
    step();
    n_checks++;
    if (parity_err !== 1'b0 || round_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_pulse: perr=%b v=%b, required 0 and 0", parity_err, round_valid);
    end
    load(KNOWN_KEY, 1'b0);
`else
    load(64'h133457799BBCDFF0, 1'b0);
`endif
    n_checks++;
    if ({parity_err, round_valid, round_cd} !== {2'b01, 56'hE19955FAACCF1E}) begin
      n_fail++;
      $display("FAIL parity_load: perr=%b v=%b cd=%h, required 0 1 E19955FAACCF1E",
               parity_err, round_valid, round_cd);
    end
    drain();
  endtask

  task automatic test_random();
    logic [63:0] k;
    bit dec;
    int j, cyc;
    for (int t = 0; t < 6; t++) begin
      k   = fix_parity({$urandom, $urandom});
      dec = 1'($urandom_range(0, 1));
      round_ready = 1'b0;
      load(k, dec);
      j = 1; cyc = 0;
      while (j <= 16 && cyc < 200) begin
        round_ready = ($urandom_range(0, 9) < 7);
        n_checks++;
        if ({round_valid, round_num, round_cd} !== {1'b1, 4'(j), model_cd(k, j, dec)}) begin
          n_fail++;
          $display("FAIL rand%0d_round%0d: v=%b n=%0d cd=%h, required cd=%h", t, j,
                   round_valid, round_num, round_cd, model_cd(k, j, dec));
        end
        step();
        if (round_ready) j++;
        cyc++;
      end
      n_checks++;
      if (j <= 16 || done !== 1'b1 || round_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_end: j=%0d done=%b v=%b, required 17 1 0", t, j, done,
                 round_valid);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_known(1'b0);
    test_known(1'b1);
    test_backpressure();
    test_load_ignored();
    test_midreset();
    test_back_to_back();
    test_parity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
